// File: rtl/led_pwm_pkg.sv
// Shared types for the LED PWM fader: channel mode encoding and breathe direction.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_FADE    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: duty/target/mode state, fade and breathe stepping, registered compare.
// Breathe direction state exists only when LED_BREATHE_EN is defined.
module led_pwm_ch
  import led_pwm_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             hw_clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt_next_i,
  input  logic             apply_i,
  input  logic             step_i,
  input  led_mode_e        mode_i,
  input  logic [PWM_W-1:0] level_i,
  output logic             pwm_o
);

  localparam logic [PWM_W-1:0] ONE  = PWM_W'(1'b1);
  localparam logic [PWM_W-1:0] ZERO = {PWM_W{1'b0}};

  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] target_q, target_d;
  led_mode_e        mode_q, mode_d;
  logic             pwm_q, pwm_d;
`ifdef LED_BREATHE_EN
  breathe_dir_e     dir_q, dir_d;
`endif

  function automatic logic [PWM_W-1:0] fade_step(input logic [PWM_W-1:0] d,
                                                 input logic [PWM_W-1:0] t);
    if (d < t) begin
      fade_step = d + ONE;
    end else if (d > t) begin
      fade_step = d - ONE;
    end else begin
      fade_step = d;
    end
  endfunction

  always_comb begin
    duty_d   = duty_q;
    target_d = target_q;
    mode_d   = mode_q;
`ifdef LED_BREATHE_EN
    dir_d    = dir_q;
`endif
    // apply_i and step_i are both tick-qualified; an apply suppresses that tick's step
    if (apply_i) begin
      mode_d = mode_i;
      case (mode_i)
        MODE_STATIC: begin
          target_d = level_i;
          duty_d   = level_i;
        end
        MODE_FADE: target_d = level_i;
        MODE_BREATHE: begin
          target_d = level_i;
`ifdef LED_BREATHE_EN
          dir_d    = (duty_q > level_i) ? DIR_DOWN : DIR_UP;
`endif
        end
        MODE_OFF: duty_d = ZERO;
        default:  duty_d = duty_q;
      endcase
    end else if (step_i) begin
      case (mode_q)
`ifdef LED_BREATHE_EN
        MODE_FADE: duty_d = fade_step(duty_q, target_q);
        MODE_BREATHE: begin
          if (dir_q == DIR_UP) begin
            if (duty_q < target_q) begin
              duty_d = duty_q + ONE;
              dir_d  = ((duty_q + ONE) == target_q) ? DIR_DOWN : DIR_UP;
            end else begin
              dir_d = DIR_DOWN;
            end
          end else begin
            if (duty_q != ZERO) begin
              duty_d = duty_q - ONE;
              dir_d  = (duty_q == ONE) ? DIR_UP : DIR_DOWN;
            end else begin
              dir_d = DIR_UP;
            end
          end
        end
`else
        MODE_FADE, MODE_BREATHE: duty_d = fade_step(duty_q, target_q);
`endif
        default: duty_d = duty_q;
      endcase
    end else begin
      duty_d = duty_q;
    end
    // compare against next-cycle counter/duty so the registered output lines up with cnt
    pwm_d = (cnt_next_i < duty_d);
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q   <= ZERO;
      target_q <= ZERO;
      mode_q   <= MODE_STATIC;
      pwm_q    <= 1'b0;
`ifdef LED_BREATHE_EN
      dir_q    <= DIR_UP;
`endif
    end else begin
      duty_q   <= duty_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      pwm_q    <= pwm_d;
`ifdef LED_BREATHE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM fader: shared period counter, free-running step divider, config handshake.
// Optional BREATHE mode is enabled by defining LED_BREATHE_EN.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 3,
  parameter  int unsigned PWM_W    = 8,
  parameter  int unsigned STEP_DIV = 65536,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PWM_W-1:0]  cfg_level,
  input  logic [1:0]        cfg_mode,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam int unsigned      DIV_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);
  localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PWM_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              step_pend_q, step_pend_d;
  logic              div_wrap_s, step_s, accept_s;
  logic              pend_valid_q, pend_valid_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [PWM_W-1:0]  pend_level_q, pend_level_d;
  led_mode_e         pend_mode_q, pend_mode_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [NUM_CH-1:0] apply_s;
  logic [NUM_CH-1:0] pwm_s;

  always_comb begin
    cnt_d  = (cnt_q == CNT_MAX) ? {PWM_W{1'b0}} : cnt_q + PWM_W'(1'b1);
    tick_d = (cnt_d == CNT_MAX);

    // steps between ticks collapse into one, consumed at the next wrap
    div_wrap_s  = (div_q == DIV_MAX);
    div_d       = div_wrap_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1'b1);
    step_s      = tick_q & (step_pend_q | div_wrap_s);
    step_pend_d = tick_q ? 1'b0 : (step_pend_q | div_wrap_s);

    accept_s     = cfg_valid & cfg_ready_q;
    pend_ch_d    = pend_ch_q;
    pend_level_d = pend_level_q;
    pend_mode_d  = pend_mode_q;
    if (accept_s) begin
      pend_valid_d = 1'b1;
      pend_ch_d    = cfg_ch;
      pend_level_d = cfg_level;
      pend_mode_d  = led_mode_e'(cfg_mode);
    end else if (tick_q) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    cfg_ready_d = ~pend_valid_d;

    // an out-of-range channel matches no index and is simply dropped at the tick
    apply_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      apply_s[i] = tick_q & pend_valid_q & (pend_ch_q == CH_W'(i));
    end
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= {PWM_W{1'b0}};
      tick_q       <= 1'b0;
      div_q        <= {DIV_W{1'b0}};
      step_pend_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= {CH_W{1'b0}};
      pend_level_q <= {PWM_W{1'b0}};
      pend_mode_q  <= MODE_STATIC;
      cfg_ready_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      div_q        <= div_d;
      step_pend_q  <= step_pend_d;
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_level_q <= pend_level_d;
      pend_mode_q  <= pend_mode_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    led_pwm_ch #(
      .PWM_W (PWM_W)
    ) u_ch (
      .hw_clk     (hw_clk),
      .rst_n      (rst_n),
      .cnt_next_i (cnt_d),
      .apply_i    (apply_s[i]),
      .step_i     (step_s),
      .mode_i     (pend_mode_q),
      .level_i    (pend_level_q),
      .pwm_o      (pwm_s[i])
    );
  end

  assign pwm_out     = pwm_s;
  assign period_tick = tick_q;
  assign cfg_ready   = cfg_ready_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed self-checking bench for led_pwm_fader (PWM_W=4, period 15, STEP_DIV=4).
// Breathe expectations follow LED_BREATHE_EN.
module tb_led_pwm_fader;
  import led_pwm_pkg::*;

  logic       hw_clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_level;
  logic [1:0] cfg_mode;
  logic [2:0] pwm_out;
  logic       period_tick;

  int n_chk  = 0;
  int n_pass = 0;

  led_pwm_fader #(
    .NUM_CH   (3),
    .PWM_W    (4),
    .STEP_DIV (4)
  ) dut (
    .hw_clk      (hw_clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_level   (cfg_level),
    .cfg_mode    (cfg_mode),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  initial hw_clk = 1'b0;
  always #5 hw_clk = ~hw_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Stops at the current negedge if it is already a tick cycle.
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (period_tick !== 1'b1 && n < 40) begin
      @(negedge hw_clk);
      n++;
    end
    chk(tag, 32'(period_tick), 32'd1);
  endtask

  task automatic cfg_write(input int ch, input int level, input led_mode_e mode, input string tag);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 40) begin
      @(negedge hw_clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_level = 4'(level);
    cfg_mode  = mode;
    @(negedge hw_clk);
    cfg_valid = 1'b0;
    chk({tag, "_busy"}, 32'(cfg_ready), 32'd0);
  endtask

  // Called at a tick negedge: samples the following 15-cycle period.
  task automatic check_period(input int ch, input int duty, input string tag, output logic rdy0);
    logic [14:0] obs;
    logic [14:0] exp;
    rdy0 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge hw_clk);
      if (k == 0) rdy0 = cfg_ready;
      obs[k] = pwm_out[ch];
      exp[k] = (k < duty);
    end
    chk(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r;
    int   fade_a[5];
    int   fade_b[3];
    int   fade_c[4];
    int   br[7];

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_level = 4'd0;
    cfg_mode  = 2'd0;
    repeat (3) @(negedge hw_clk);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge hw_clk);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);

    // STATIC level 5 on red
    cfg_write(0, 5, MODE_STATIC, "w_static5");
    wait_tick("t1_tick");
    chk("t1_ready_at_tick", 32'(cfg_ready), 32'd0);
    check_period(0, 5, "t1_p1", r);
    chk("t1_ready_back", 32'(r), 32'd1);
    check_period(0, 5, "t1_p2", r);

    // levels 0 then 15 on green
    cfg_write(1, 0, MODE_STATIC, "w_ch1_0");
    wait_tick("t2_tick0");
    check_period(1, 0, "t2_lvl0", r);
    cfg_write(1, 15, MODE_STATIC, "w_ch1_15");
    wait_tick("t2_tick15");
    check_period(1, 15, "t2_lvl15_p1", r);
    check_period(1, 15, "t2_lvl15_p2", r);

    // FADE blue 0 -> 3, then up toward 7, then retarget down to 4
    fade_a = '{0, 1, 2, 3, 3};
    cfg_write(2, 3, MODE_FADE, "w_fade3");
    wait_tick("t3_tick_a");
    for (int i = 0; i < 5; i++) check_period(2, fade_a[i], $sformatf("t3_fade3_%0d", i), r);
    fade_b = '{3, 4, 5};
    cfg_write(2, 7, MODE_FADE, "w_fade7");
    wait_tick("t3_tick_b");
    for (int i = 0; i < 3; i++) check_period(2, fade_b[i], $sformatf("t3_fade7_%0d", i), r);
    fade_c = '{6, 5, 4, 4};
    cfg_write(2, 4, MODE_FADE, "w_fade4");
    chk("t3_pre_retarget", 32'(pwm_out[2]), 32'd1);
    wait_tick("t3_tick_c");
    for (int i = 0; i < 4; i++) check_period(2, fade_c[i], $sformatf("t3_fade4_%0d", i), r);

    // OFF red, then BREATHE target 2
    cfg_write(0, 0, MODE_OFF, "w_off");
    wait_tick("t4_tick_off");
    check_period(0, 0, "t4_off", r);
`ifdef LED_BREATHE_EN
    br = '{0, 1, 2, 1, 0, 1, 2};
`else
    br = '{0, 1, 2, 2, 2, 2, 2};
`endif
    cfg_write(0, 2, MODE_BREATHE, "w_breathe2");
    wait_tick("t4_tick_br");
    for (int i = 0; i < 7; i++) check_period(0, br[i], $sformatf("t4_breathe_%0d", i), r);

    // out-of-range channel, second write held off until the tick
    cfg_write(3, 9, MODE_STATIC, "w_badch");
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_level = 4'd7;
    cfg_mode  = MODE_STATIC;
    wait_tick("t5_tick");
    chk("t5_ready_held", 32'(cfg_ready), 32'd0);
    check_period(1, 15, "t5_ch1_kept", r);
    chk("t5_ready_after_discard", 32'(r), 32'd1);
    cfg_valid = 1'b0;
    check_period(1, 7, "t5_ch1_7", r);
    check_period(2, 4, "t5_ch2_kept", r);

    // reset in the middle of a fade
    cfg_write(2, 12, MODE_FADE, "w_fade12");
    wait_tick("t6_tick");
    check_period(2, 4, "t6_fade_0", r);
    check_period(2, 5, "t6_fade_1", r);
    repeat (3) @(negedge hw_clk);
    chk("t6_pre_rst_pwm", 32'(pwm_out), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_tick", 32'(period_tick), 32'd0);
    chk("t6_rst_ready", 32'(cfg_ready), 32'd0);
    @(negedge hw_clk);
    rst_n = 1'b1;
    @(negedge hw_clk);
    chk("t6_ready_rise", 32'(cfg_ready), 32'd1);
    wait_tick("t6_tick_post");
    check_period(2, 0, "t6_ch2_p1", r);
    check_period(1, 0, "t6_ch1_p2", r);
    check_period(2, 0, "t6_ch2_p3", r);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
